// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit and the datapath:
// opcodes, FSM state encoding, ALU operation codes and mux select codes.
package mc_ctrl_pkg;

  localparam int OPC_W_DEF = 6;

  localparam logic [5:0] OP_AND  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ANDI = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_BNE  = 6'd8;
  localparam logic [5:0] OP_J    = 6'd9;
  localparam logic [5:0] OP_HALT = 6'd10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  // ALU function for R-type and immediate arithmetic opcodes.
  function automatic logic [2:0] alu_op_for(input logic [5:0] opc);
    logic [2:0] op;
    case (opc)
      OP_AND, OP_ANDI: op = ALU_AND;
      OP_SUB:          op = ALU_SUB;
      OP_ADD, OP_ADDI: op = ALU_ADD;
      default:         op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode classifier for the multicycle control unit.
// Exactly one class output is high for any opcode value.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_rtype,
  output logic             is_itype,
  output logic             is_load,
  output logic             is_store,
  output logic             is_branch,
  output logic             is_jump,
  output logic             is_halt,
  output logic             is_illegal
);

  // Classify the opcode; anything not listed is illegal.
  always_comb begin
    is_rtype   = 1'b0;
    is_itype   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_W'(OP_AND), OPC_W'(OP_ADD), OPC_W'(OP_SUB): is_rtype  = 1'b1;
      OPC_W'(OP_ANDI), OPC_W'(OP_ADDI):               is_itype  = 1'b1;
      OPC_W'(OP_LW):                                  is_load   = 1'b1;
      OPC_W'(OP_SW):                                  is_store  = 1'b1;
      OPC_W'(OP_BEQ), OPC_W'(OP_BNE):                 is_branch = 1'b1;
      OPC_W'(OP_J):                                   is_jump   = 1'b1;
      OPC_W'(OP_HALT):                                is_halt   = 1'b1;
      default:                                        is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle FSM control unit: FETCH/DECODE/EXEC/MEM/WB with memory-wait stalls.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic       pc_write_s, ir_write_s, iord_s, mem_read_s, mem_write_s;
  logic       reg_write_s, reg_dst_s, mem_to_reg_s, alu_src_a_s, halted_s;
  logic [1:0] pc_src_s, alu_src_b_s;
  logic [2:0] alu_op_s;

  logic is_rtype, is_itype, is_load, is_store;
  logic is_branch, is_jump, is_halt, is_illegal;

  mc_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode    (opcode),
    .is_rtype  (is_rtype),
    .is_itype  (is_itype),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .is_halt   (is_halt),
    .is_illegal(is_illegal)
  );

  // State and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and control outputs from the registered state plus gating inputs.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    pc_write_s   = 1'b0;
    pc_src_s     = PC_ALU;
    ir_write_s   = 1'b0;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = SRCB_REG;
    alu_op_s     = ALU_ADD;
    halted_s     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = SRCB_ONE;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // ALUOut captures PC + imm here so EXEC can branch without recomputing.
        alu_src_b_s = SRCB_IMM;
        if (is_jump) begin
          pc_write_s = 1'b1;
          pc_src_s   = PC_JUMP;
          state_d    = S_FETCH;
        end else if (is_halt) begin
          state_d = S_HALTED;
        end else if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_rtype) begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = SRCB_REG;
          alu_op_s    = alu_op_for(6'(opcode));
          state_d     = S_WB;
        end else if (is_itype) begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = SRCB_IMM;
          alu_op_s    = alu_op_for(6'(opcode));
          state_d     = S_WB;
        end else if (is_load || is_store) begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = SRCB_IMM;
          alu_op_s    = ALU_ADD;
          state_d     = S_MEM;
        end else if (is_branch) begin
          alu_src_a_s = 1'b1;
          alu_src_b_s = SRCB_REG;
          alu_op_s    = ALU_SUB;
          pc_src_s    = PC_ALUOUT;
          pc_write_s  = (opcode == OPC_W'(OP_BEQ)) ? alu_zero : ~alu_zero;
          state_d     = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        iord_s = 1'b1;
        if (is_load) begin
          mem_read_s = 1'b1;
          state_d    = mem_ready ? S_WB : S_MEM;
        end else if (is_store) begin
          mem_write_s = 1'b1;
          state_d     = mem_ready ? S_FETCH : S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        if (is_rtype) begin
          reg_dst_s = 1'b1;
        end else if (is_load) begin
          mem_to_reg_s = 1'b1;
        end else begin
          reg_dst_s = 1'b0;
        end
        state_d = S_FETCH;
      end
      S_HALTED: begin
        halted_s = 1'b1;
        state_d  = S_HALTED;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset masks every output immediately, so an aborted instruction drops its strobes.
  assign pc_write   = pc_write_s & ~rst;
  assign pc_src     = rst ? 2'b00 : pc_src_s;
  assign ir_write   = ir_write_s & ~rst;
  assign iord       = iord_s & ~rst;
  assign mem_read   = mem_read_s & ~rst;
  assign mem_write  = mem_write_s & ~rst;
  assign reg_write  = reg_write_s & ~rst;
  assign reg_dst    = reg_dst_s & ~rst;
  assign mem_to_reg = mem_to_reg_s & ~rst;
  assign alu_src_a  = alu_src_a_s & ~rst;
  assign alu_src_b  = rst ? 2'b00 : alu_src_b_s;
  assign alu_op     = rst ? 3'b000 : alu_op_s;
  assign state      = rst ? 3'b000 : state_q;
  assign halted     = halted_s & ~rst;
  assign illegal    = illegal_q & ~rst;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
  logic             retire_s;

  // Last cycle of an instruction.
  always_comb begin
    retire_s = 1'b0;
    case (state_q)
      S_DECODE: retire_s = is_jump | is_halt | is_illegal;
      S_EXEC:   retire_s = is_branch;
      S_MEM:    retire_s = is_store & mem_ready;
      S_WB:     retire_s = 1'b1;
      default:  retire_s = 1'b0;
    endcase
  end

  // Free-running cycle and retired-instruction counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q <= {CNT_W{1'b0}};
      instr_cnt_q <= {CNT_W{1'b0}};
    end else begin
      cycle_cnt_q <= cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      instr_cnt_q <= instr_cnt_q + {{(CNT_W-1){1'b0}}, retire_s};
    end
  end

  assign cycle_cnt = rst ? {CNT_W{1'b0}} : cycle_cnt_q;
  assign instr_cnt = rst ? {CNT_W{1'b0}} : instr_cnt_q;
`else
  assign cycle_cnt = {CNT_W{1'b0}};
  assign instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: an instruction-level reference model
// expands each instruction into its expected per-cycle control pattern.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, halted, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [2:0]  alu_op, state;
  logic [31:0] cycle_cnt, instr_cnt;

  mc_control_unit #(.OPC_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .halted(halted),
    .illegal(illegal), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw, iord, mrd, mwr, rw, rdst, m2r, sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic       hlt, ill;
  } ctl_t;

  typedef struct {
    logic       mr, az, ret;
    logic [5:0] opc;
    ctl_t       v, m;
  } ent_t;

  ent_t        q[$];
  logic        gen_ill;
  logic [31:0] exp_cyc, exp_ins;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t o;
    o.st = state; o.pcw = pc_write; o.pcs = pc_src; o.irw = ir_write; o.iord = iord;
    o.mrd = mem_read; o.mwr = mem_write; o.rw = reg_write; o.rdst = reg_dst;
    o.m2r = mem_to_reg; o.sa = alu_src_a; o.sb = alu_src_b; o.op = alu_op;
    o.hlt = halted; o.ill = illegal;
    return o;
  endfunction

  // Strobes, state, halted and illegal are always checked; other fields per phase.
  task automatic push(input ctl_t v, input ctl_t m, input logic mr, input logic az,
                      input logic [5:0] opc, input logic ret);
    ent_t e;
    v.ill = gen_ill;
    m.st = 3'b111; m.pcw = 1'b1; m.irw = 1'b1; m.mrd = 1'b1; m.mwr = 1'b1;
    m.rw = 1'b1; m.hlt = 1'b1; m.ill = 1'b1;
    e.v = v; e.m = m; e.mr = mr; e.az = az; e.opc = opc; e.ret = ret;
    q.push_back(e);
  endtask

  task automatic gen_instr(input int opc, input int wf, input int wm, input logic az,
                           output logic stop);
    ctl_t v, m;
    logic [5:0] o6;
    bit r, im, lw, sw, br, j, hl, il;
    o6 = 6'(opc);
    r  = (opc <= 2); im = (opc == 3 || opc == 4); lw = (opc == 5); sw = (opc == 6);
    br = (opc == 7 || opc == 8); j = (opc == 9); hl = (opc == 10); il = (opc > 10);
    stop = 1'b0;
    for (int i = 0; i <= wf; i++) begin
      v = '0; m = '0;
      v.st = 3'd0; v.mrd = 1'b1; v.sb = 2'd1;
      m.iord = 1'b1; m.sa = 1'b1; m.sb = 2'b11; m.op = 3'b111; m.pcs = 2'b11;
      if (i == wf) begin v.irw = 1'b1; v.pcw = 1'b1; end
      push(v, m, (i == wf), 1'($urandom), 6'($urandom), 1'b0);
    end
    v = '0; m = '0;
    v.st = 3'd1; v.sb = 2'd2;
    m.sa = 1'b1; m.sb = 2'b11; m.op = 3'b111;
    if (j) begin
      v.pcw = 1'b1; v.pcs = 2'd2; m.pcs = 2'b11;
      push(v, m, 1'($urandom), 1'($urandom), o6, 1'b1);
      return;
    end
    if (hl) begin
      push(v, m, 1'($urandom), 1'($urandom), o6, 1'b1);
      for (int i = 0; i < 20; i++) begin
        v = '0; m = '0;
        v.st = 3'd5; v.hlt = 1'b1;
        push(v, m, 1'(i), 1'($urandom), 6'($urandom), 1'b0);
      end
      stop = 1'b1;
      return;
    end
    if (il) begin
      push(v, m, 1'($urandom), 1'($urandom), o6, 1'b1);
      gen_ill = 1'b1;
      return;
    end
    push(v, m, 1'($urandom), 1'($urandom), o6, 1'b0);
    v = '0; m = '0;
    v.st = 3'd2;
    if (r) begin
      v.sa = 1'b1; v.sb = 2'd0; v.op = (opc == 0) ? 3'd2 : (opc == 1) ? 3'd0 : 3'd1;
      m.sa = 1'b1; m.sb = 2'b11; m.op = 3'b111;
    end else if (im) begin
      v.sb = 2'd2; m.sb = 2'b11;
    end else if (lw || sw) begin
      v.sa = 1'b1; v.sb = 2'd2; v.op = 3'd0;
      m.sa = 1'b1; m.sb = 2'b11; m.op = 3'b111;
    end else begin
      v.sa = 1'b1; v.sb = 2'd0; v.op = 3'd1; v.pcs = 2'd1;
      m.sa = 1'b1; m.sb = 2'b11; m.op = 3'b111; m.pcs = 2'b11;
      v.pcw = (opc == 7) ? az : !az;
      push(v, m, 1'($urandom), az, o6, 1'b1);
      return;
    end
    push(v, m, 1'($urandom), 1'($urandom), o6, 1'b0);
    if (lw || sw) begin
      for (int i = 0; i <= wm; i++) begin
        v = '0; m = '0;
        v.st = 3'd3; v.iord = 1'b1; m.iord = 1'b1;
        if (lw) v.mrd = 1'b1; else v.mwr = 1'b1;
        push(v, m, (i == wm), 1'($urandom), o6, sw && (i == wm));
      end
      if (sw) return;
    end
    v = '0; m = '0;
    v.st = 3'd4; v.rw = 1'b1; v.rdst = r; v.m2r = lw;
    m.rdst = 1'b1; m.m2r = 1'b1;
    push(v, m, 1'($urandom), 1'($urandom), o6, 1'b1);
  endtask

  task automatic check_counters();
`ifdef MC_PERF_CNT_EN
    check_eq("cnt", {cycle_cnt, instr_cnt}, {exp_cyc, exp_ins});
`else
    check_eq("cnt", {cycle_cnt, instr_cnt}, 64'd0);
`endif
  endtask

  task automatic apply_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'($urandom); alu_zero = 1'($urandom); opcode = 6'($urandom);
      #1;
      check_eq("rst_ctl", 64'(observe()), 64'd0);
      check_eq("rst_cnt", {cycle_cnt, instr_cnt}, 64'd0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    q.delete();
    gen_ill = 1'b0;
    exp_cyc = 32'd0;
    exp_ins = 32'd0;
  endtask

  task automatic run_queue(input int n);
    ent_t e;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      e = q.pop_front();
      @(negedge clk);
      mem_ready = e.mr; alu_zero = e.az; opcode = e.opc;
      #1;
      check_eq("ctl", 64'(observe() & e.m), 64'(e.v & e.m));
      check_counters();
      @(posedge clk);
      exp_cyc = exp_cyc + 32'd1;
      if (e.ret) exp_ins = exp_ins + 32'd1;
    end
  endtask

  initial begin
    logic stop;
    int   n, opc, cut;
    apply_reset(2);
    gen_instr(1, 0, 0, 1'b0, stop);
    gen_instr(5, 0, 3, 1'b0, stop);
    gen_instr(7, 0, 0, 1'b1, stop);
    gen_instr(8, 0, 0, 1'b1, stop);
    gen_instr(63, 0, 0, 1'b0, stop);
    gen_instr(2, 1, 0, 1'b0, stop);
    gen_instr(9, 0, 0, 1'b0, stop);
    gen_instr(10, 0, 0, 1'b0, stop);
    run_queue(q.size());

    apply_reset(1);
    gen_instr(6, 1, 6, 1'b0, stop);
    run_queue(7);
    apply_reset(1);

    for (int p = 0; p < 30; p++) begin
      n = 1 + int'($urandom_range(0, 9));
      stop = 1'b0;
      for (int i = 0; i < n && !stop; i++) begin
        opc = int'($urandom_range(0, 15));
        if (opc > 10) opc = int'($urandom_range(11, 63));
        gen_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                  1'($urandom), stop);
      end
      cut = q.size();
      if ($urandom_range(0, 3) == 0 && q.size() > 1) cut = int'($urandom_range(1, q.size() - 1));
      run_queue(cut);
      apply_reset(1 + int'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle FSM control unit for the RISC core.
- Sits directly upstream of the datapath, inside design2. Consumes IR opcode, ALU zero flag and the unified-memory ready strobe; drives every datapath mux select, register/PC/IR write enable and memory strobe.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with memory-wait stalls.

Parameters:
- OPC_W, 6, opcode field width.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPC_W  IR[31:26], valid from DECODE onward.
- alu_zero  in  1  ALU zero flag, combinational from current operands.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write  out  1  load PC.
- pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=reserved.
- ir_write  out  1  load IR from memory data.
- iord  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write.
- reg_dst  out  1  0=rt, 1=rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  0=reg B, 1=constant 1, 2=sign-extended imm.
- alu_op  out  3  0=ADD, 1=SUB, 2=AND.
- state  out  3  current state, for debug.
- halted  out  1  core stopped.
- illegal  out  1  sticky: an undefined opcode was decoded.
- cycle_cnt  out  CNT_W  cycles since reset (optional feature).
- instr_cnt  out  CNT_W  retired instructions (optional feature).

Behaviour:
- Opcodes: AND=0, ADD=1, SUB=2, ANDI=3, ADDI=4, LW=5, SW=6, BEQ=7, BNE=8, J=9, HALT=10; all others are illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.
- Reset:
  - While rst=1, every output is 0 and state is forced to FETCH.
  - illegal clears; counters clear.
  - rst mid-instruction aborts it with no further write strobes.
- FETCH:
  - Asserts mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - ir_write and pc_write assert only in the cycle mem_ready=1, which also moves the FSM to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE (1 cycle): alu_src_a=0, alu_src_b=2, alu_op=ADD, which precomputes the branch target into ALUOut. Transitions:
  - J: pc_write=1, pc_src=2, then FETCH.
  - HALT: go to HALTED.
  - Illegal opcode: set illegal, then FETCH (treated as NOP).
  - All others: go to EXEC.
- EXEC (1 cycle):
  - R-type: alu_src_a=1, alu_src_b=0, alu_op per opcode, then WB.
  - ANDI/ADDI: alu_src_b=2, then WB.
  - LW/SW: alu_src_a=1, alu_src_b=2, ADD, then MEM.
  - BEQ/BNE: alu_src_a=1, alu_src_b=0, SUB, pc_src=1. pc_write = alu_zero for BEQ, !alu_zero for BNE. Then FETCH.
- MEM:
  - iord=1; mem_read (LW) or mem_write (SW) held until mem_ready=1.
  - On ready: LW goes to WB, SW goes to FETCH.
  - The strobe stays asserted during the whole wait.
- WB (1 cycle): reg_write=1, then FETCH.
  - R-type: reg_dst=1, mem_to_reg=0.
  - I-type: reg_dst=0, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
- HALTED: all strobes 0, halted=1; exits only on rst.
- Zero-wait CPI: R/I 4, LW 5, SW 4, branch 3, J 2. Each memory-wait cycle adds 1.
- Outputs are combinational from the registered state plus the gating inputs named above. There are no write strobes in any state not listed.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined:
  - cycle_cnt increments every non-reset cycle, including HALTED.
  - instr_cnt increments on the last cycle of each retired instruction: J/illegal DECODE, branch EXEC, SW MEM with ready, WB, HALT entry.
  - Both counters wrap modulo 2^CNT_W.
- When undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared header/package mc_ctrl_pkg holds the opcode constants, state encodings, alu_op codes, pc_src and alu_src_b codes. The datapath uses it too.
- One sub-module, mc_ctrl_decode: combinational opcode classifier producing is_rtype, is_itype, is_load, is_store, is_branch, is_jump, is_halt and is_illegal.

Test Plan:
- ADD with mem_ready tied 1 -> states 0,1,2,4,0; reg_write=1 only in WB, reg_dst=1; exactly 4 cycles.
- LW with mem_ready low for 3 cycles in MEM -> mem_read and iord=1 held 4 cycles; WB has mem_to_reg=1; 8 cycles total.
- BEQ with alu_zero=1 -> pc_write=1, pc_src=1 in EXEC. BNE with alu_zero=1 -> pc_write=0 throughout EXEC.
- Opcode 63 -> illegal rises after DECODE and stays 1; next fetch proceeds; illegal clears only on rst.
- HALT, then toggling mem_ready for 20 cycles -> halted=1 and all strobes 0; rst for 1 cycle -> state=FETCH, halted=0.
- Assert rst in MEM of SW while mem_ready=0 -> mem_write drops in the same cycle rst is sampled; FSM restarts in FETCH. With MC_PERF_CNT_EN, both counters read 0 after reset.
